// File: rtl/abs_diff_approx_pipe_if.sv
// Operand/result handshake bundle for abs_diff_approx_pipe, including the error-statistics outputs.
interface abs_diff_approx_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int TW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TW-1:0]    cfg_trunc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic [WIDTH-1:0] out_err;
    logic             stats_clr;
    logic [WIDTH-1:0] err_max;
    logic [CNT_W-1:0] err_cnt;
    logic             et_viol;

    modport master (
        output in_valid, in_a, in_b, cfg_trunc, out_ready, stats_clr,
        input  in_ready, out_valid, out_diff, out_err, err_max, err_cnt, et_viol
    );

    modport slave (
        input  in_valid, in_a, in_b, cfg_trunc, out_ready, stats_clr,
        output in_ready, out_valid, out_diff, out_err, err_max, err_cnt, et_viol
    );
endinterface

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage pipelined approximate |a-b| with runtime LSB truncation and a valid/ready handshake.
// Error statistics (err_max, err_cnt, et_viol) are built only when ABS_DIFF_ERR_STATS_EN is defined.
module abs_diff_approx_pipe #(
    parameter int WIDTH = 4,
    parameter int ET    = 3,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    abs_diff_approx_pipe_if.slave bus
);
    localparam int            TW        = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TRUNC_MAX = TW'(WIDTH);

    logic             r_s1Valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [TW-1:0]    r_trunc;
    logic             r_s2Valid;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_err;

    logic             w_s1Load;
    logic             w_s2Load;
    logic             w_inReady;
    logic [TW-1:0]    w_truncEff;
    logic [WIDTH-1:0] w_exact;
    logic [WIDTH-1:0] w_lowMask;

    // s1 can take new operands whenever it is empty or draining into s2 this cycle.
    always_comb begin
        w_s2Load   = r_s1Valid && (!r_s2Valid || bus.out_ready);
        w_inReady  = !r_s1Valid || w_s2Load;
        w_s1Load   = bus.in_valid && w_inReady;
        w_truncEff = (bus.cfg_trunc > TRUNC_MAX) ? TRUNC_MAX : bus.cfg_trunc;
    end

    always_comb begin
        w_exact   = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);
        w_lowMask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_lowMask[i] = (i < int'(r_trunc));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_trunc   <= '0;
        end else if (w_s1Load) begin
            r_s1Valid <= 1'b1;
            r_a       <= bus.in_a;
            r_b       <= bus.in_b;
            r_trunc   <= w_truncEff;
        end else if (w_s2Load) begin
            r_s1Valid <= 1'b0;
        end
    end

    // s2 only reloads when its current result is gone, so a stalled result holds stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_diff    <= '0;
            r_err     <= '0;
        end else if (w_s2Load) begin
            r_s2Valid <= 1'b1;
            r_diff    <= w_exact & ~w_lowMask;
            r_err     <= w_exact & w_lowMask;
        end else if (bus.out_ready) begin
            r_s2Valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_s2Valid;
    assign bus.out_diff  = r_diff;
    assign bus.out_err   = r_err;

`ifdef ABS_DIFF_ERR_STATS_EN
    logic             r_errMax;
    logic [WIDTH-1:0] r_errMaxVal;
    logic [CNT_W-1:0] r_errCnt;
    logic             r_etViol;
    logic             w_outFire;

    assign w_outFire = r_s2Valid && bus.out_ready;

    // A clear in the same cycle as a delivery wins; that delivery is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errMaxVal <= '0;
            r_errCnt    <= '0;
            r_etViol    <= 1'b0;
        end else if (bus.stats_clr) begin
            r_errMaxVal <= '0;
            r_errCnt    <= '0;
            r_etViol    <= 1'b0;
        end else if (w_outFire) begin
            if (r_err > r_errMaxVal) begin
                r_errMaxVal <= r_err;
            end
            if ((r_err != '0) && (r_errCnt != '1)) begin
                r_errCnt <= r_errCnt + CNT_W'(1);
            end
            if (int'(r_err) > ET) begin
                r_etViol <= 1'b1;
            end
        end
    end

    assign r_errMax    = 1'b0;
    assign bus.err_max = r_errMaxVal;
    assign bus.err_cnt = r_errCnt;
    assign bus.et_viol = r_etViol;
`else
    logic w_unusedStatsClr;

    assign w_unusedStatsClr = bus.stats_clr;
    assign bus.err_max      = '0;
    assign bus.err_cnt      = '0;
    assign bus.et_viol      = 1'b0;
`endif
endmodule
